wptr_full_status: RTL and testbench

Write-domain pointer and status block for the asynchronous FIFO: a parametrised successor to the basic write-pointer/full logic. Keeps an (ADDR_W+1)-bit binary write counter and a registered Gray-coded write pointer for the read domain. From the already-synchronised read pointer it derives registered full, fill level and programmable almost-full, plus an optional sticky overflow flag. Sits in the write clock domain between the writer, the FIFO memory and the read-pointer synchroniser.

---
 rtl/wptr_full_status.sv | 91 +++++++++
 tb/tb_wptr_full_status.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_status.sv
// Write-domain pointer/status block for an async FIFO: binary + Gray write pointer,
// registered full, fill level and almost-full. Optional sticky overflow via WPTR_FULL_OVF_EN.
module wptr_full_status #(
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inc,
    input  logic [ADDR_W:0]   i_rPtr,
    input  logic [ADDR_W:0]   i_afTh,
    input  logic              i_ovfClr,
    output logic [ADDR_W:0]   o_wPtr,
    output logic [ADDR_W-1:0] o_wAddr,
    output logic              o_wrEn,
    output logic              o_full,
    output logic              o_almostFull,
    output logic [ADDR_W:0]   o_level,
    output logic              o_overflow
);

    logic [ADDR_W:0] wbin_q, wbin_d;
    logic [ADDR_W:0] wgray_q, wgray_d;
    logic [ADDR_W:0] level_q, level_d;
    logic [ADDR_W:0] rbin;
    logic            full_q, full_d;
    logic            af_q, af_d;

    assign o_wrEn  = i_inc && !full_q;
    assign wbin_d  = wbin_q + {{ADDR_W{1'b0}}, o_wrEn};
    assign wgray_d = (wbin_d >> 1) ^ wbin_d;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it
    generate
        for (genvar gi = 0; gi <= ADDR_W; gi++) begin : g_rbin
            assign rbin[gi] = ^i_rPtr[ADDR_W:gi];
        end
    endgenerate

    assign level_d = wbin_d - rbin;
    assign full_d  = (wgray_d == {~i_rPtr[ADDR_W:ADDR_W-1], i_rPtr[ADDR_W-2:0]});
    assign af_d    = (level_d >= i_afTh);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
        end
    end

`ifdef WPTR_FULL_OVF_EN
    logic ovf_q, ovf_d;

    // Set has priority over clear so a drop in the clearing cycle is not lost
    always_comb begin
        ovf_d = ovf_q;
        if (i_ovfClr)
            ovf_d = 1'b0;
        if (i_inc && full_q)
            ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign o_overflow = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = i_ovfClr;
    assign o_overflow     = 1'b0;
`endif

    assign o_wAddr      = wbin_q[ADDR_W-1:0];
    assign o_wPtr       = wgray_q;
    assign o_level      = level_q;
    assign o_full       = full_q;
    assign o_almostFull = af_q;

endmodule

// File: tb/tb_wptr_full_status.sv
// Scoreboard bench for wptr_full_status at ADDR_W=2: stimulus pushes expected
// post-edge outputs, a negedge monitor pops and compares.
module tb_wptr_full_status;

`ifdef WPTR_FULL_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       inc = 1'b0;
    logic [2:0] rptr = '0;
    logic [2:0] af_th = 3'd3;
    logic       ovf_clr = 1'b0;
    logic [2:0] w_ptr;
    logic [1:0] w_addr;
    logic       wr_en;
    logic       full;
    logic       almost_full;
    logic [2:0] level;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] a;
        logic [2:0] p;
        logic [2:0] l;
        logic       f;
        logic       af;
        logic       ov;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic [2:0] prev_ptr = '0;

    wptr_full_status #(.ADDR_W(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_inc        (inc),
        .i_rPtr       (rptr),
        .i_afTh       (af_th),
        .i_ovfClr     (ovf_clr),
        .o_wPtr       (w_ptr),
        .o_wAddr      (w_addr),
        .o_wrEn       (wr_en),
        .o_full       (full),
        .o_almostFull (almost_full),
        .o_level      (level),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            $display("[TB] ok %s: %0h", nm, act);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational write enable,
    // then queue the outputs expected after the edge.
    task automatic step(input bit i, input logic [2:0] rp, input bit clr, input bit e_wren,
                        input logic [1:0] ea, input logic [2:0] ep, input logic [2:0] el,
                        input bit ef, input bit eaf, input bit eov, input string nm);
        exp_t e;
        inc     = i;
        rptr    = rp;
        ovf_clr = clr;
        #1;
        chk({nm, "_wren"}, int'(wr_en), int'(e_wren));
        @(posedge clk);
        e = '{a: ea, p: ep, l: el, f: ef, af: eaf, ov: eov};
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
    endtask

    always @(negedge rst_n) prev_ptr = '0;

    always @(negedge clk) begin
        exp_t  e;
        exp_t  act;
        string nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = '{a: w_addr, p: w_ptr, l: level, f: full, af: almost_full, ov: overflow};
            chk(nm, int'(act), int'(e));
        end
        if (w_ptr !== prev_ptr)
            chk("gray_flip", $countones(w_ptr ^ prev_ptr), 1);
        prev_ptr = w_ptr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] wb;
        rst_n = 1'b0;
        #2;
        chk("reset", int'({w_addr, w_ptr, level, full, almost_full, overflow}), 0);
        #10;
        rst_n = 1'b1;

        // fill from empty
        step(1, 3'd0, 0, 1, 2'd1, 3'd1, 3'd1, 0, 0, 0, "wr1");
        step(1, 3'd0, 0, 1, 2'd2, 3'd3, 3'd2, 0, 0, 0, "wr2");
        step(1, 3'd0, 0, 1, 2'd3, 3'd2, 3'd3, 0, 1, 0, "wr3");
        step(1, 3'd0, 0, 1, 2'd0, 3'd6, 3'd4, 1, 1, 0, "wr4");

        // writes while full are dropped
        step(1, 3'd0, 0, 0, 2'd0, 3'd6, 3'd4, 1, 1, OVF, "hold1");
        step(1, 3'd0, 0, 0, 2'd0, 3'd6, 3'd4, 1, 1, OVF, "hold2");
        step(1, 3'd0, 0, 0, 2'd0, 3'd6, 3'd4, 1, 1, OVF, "hold3");
        step(1, 3'd0, 1, 0, 2'd0, 3'd6, 3'd4, 1, 1, OVF, "set_wins");
        step(0, 3'd0, 1, 0, 2'd0, 3'd6, 3'd4, 1, 1, 0, "ovf_clr");
        step(0, 3'd0, 0, 0, 2'd0, 3'd6, 3'd4, 1, 1, 0, "ovf_low");

        // read pointer advance releases full, one write refills
        step(0, 3'd1, 0, 0, 2'd0, 3'd6, 3'd3, 0, 1, 0, "rd1");
        step(1, 3'd1, 0, 1, 2'd1, 3'd7, 3'd4, 1, 1, 0, "refill");

        // simultaneous write and read at level 2
        step(0, 3'd2, 0, 0, 2'd1, 3'd7, 3'd2, 0, 0, 0, "rd_to2");
        step(1, 3'd6, 0, 1, 2'd2, 3'd5, 3'd2, 0, 0, 0, "wr_rd");

        // 40 writes with the reader one behind: wraps 7->0 five times
        wb = 3'd6;
        for (int k = 0; k < 40; k++) begin
            logic [2:0] rp;
            rp = gray(wb);
            wb = wb + 3'd1;
            step(1, rp, 0, 1, wb[1:0], gray(wb), 3'd1, 0, 0, 0, "track");
        end

        // almost-full threshold extremes
        af_th = 3'd0;
        step(0, gray(wb - 3'd1), 0, 0, wb[1:0], gray(wb), 3'd1, 0, 1, 0, "af_th0");
        af_th = 3'd5;
        step(0, gray(wb - 3'd1), 0, 0, wb[1:0], gray(wb), 3'd1, 0, 0, 0, "af_th5");
        af_th = 3'd3;
        for (int k = 0; k < 2; k++) begin
            logic [2:0] rp;
            rp = gray(wb);
            wb = wb + 3'd1;
            step(1, rp, 0, 1, wb[1:0], gray(wb), 3'd1, 0, 0, 0, "burst");
        end

        // asynchronous reset between edges, after the monitor has drained
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_rst", int'({w_addr, w_ptr, level, full, almost_full, overflow}), 0);
        rst_n = 1'b1;
        inc   = 1'b1;
        rptr  = 3'd0;
        #1;
        chk("first_addr", int'(w_addr), 0);
        step(1, 3'd0, 0, 1, 2'd1, 3'd1, 3'd1, 0, 0, 0, "post_rst");
        inc = 1'b0;

        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
